// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Data-memory responder for the core's load/store port. It accepts one
//   request at a time over a valid/ready handshake and waits WAIT_CYCLES extra
//   cycles. It then performs a byte, halfword or word access on a word-organised
//   array and returns the load data or an error over a second valid/ready
//   handshake. Requests are never overlapped with responses.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit storage words (power of two, >= 4)
//   WAIT_CYCLES  wait states between request accept and the access (0..15)
//   ADDR_BASE    byte address mapped to word 0 (word aligned)
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   req_valid    request present
//   req_ready    responder can accept a request (high only in IDLE)
//   req_we       1 = store, 0 = load
//   req_funct3   RV32 funct3: access size and sign
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   rsp_valid    response present (high only in RESP)
//   rsp_ready    requester accepts the response
//   rsp_rdata    extended load data; 0 for stores and errors
//   rsp_err      access faulted; no store performed
//
// Configuration macro:
//   DMEM_MISALIGN_CHECK_EN  when defined, a misaligned halfword or word access
//                           faults. When undefined, the access is silently
//                           forced to natural alignment.
//
// Memory contents are not reset.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    // Span of the mapped window in bytes. The extra bit keeps the compare exact
    // even when the window reaches the top of the 32-bit space.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_t;

    state_t state, state_next;

    // Storage and the latched request.
    logic [31:0]      mem [DEPTH_WORDS];
    logic [3:0]       cnt;
    logic             lat_we;
    logic [2:0]       lat_funct3;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [31:0]      rdata_reg;
    logic             err_reg;

    // Decode of the latched request.
    logic [31:0]      off;
    logic             out_of_range;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             funct_ok;
    logic             misaligned;
    logic             access_err;
    logic             access_fire;
    logic             mem_we;
    logic [31:0]      mem_word;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;
    logic [31:0]      load_data;
    logic [31:0]      wr_word;

    // -------------------------------------------------------------------------
    // Address and command decode
    // -------------------------------------------------------------------------
    assign off          = lat_addr - ADDR_BASE;
    assign out_of_range = (lat_addr < ADDR_BASE) || ({1'b0, off} >= SPAN_BYTES);
    assign word_idx     = off[IDX_W+1:2];
    assign lane         = off[1:0];

    always_comb begin
        funct_ok = 1'b0;
        if (lat_we) begin
            funct_ok = lat_funct3 inside {F3_B, F3_H, F3_W};
        end else begin
            funct_ok = lat_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    // funct3[1:0] encodes the size for every legal access: 0 byte, 1 half, 2 word.
    assign misaligned = ((lat_funct3[1:0] == 2'd1) && lane[0]) ||
                        ((lat_funct3[1:0] == 2'd2) && (lane != 2'b00));
`else
    // Misalignment is absorbed by the lane selection below: halfwords use
    // lane[1] only and words ignore the lane entirely.
    assign misaligned = 1'b0;
`endif

    assign access_err  = out_of_range || !funct_ok || misaligned;
    assign access_fire = (state == StWait) && (cnt == 4'd0);
    assign mem_we      = access_fire && lat_we && !access_err;

    // -------------------------------------------------------------------------
    // Load extraction and store merge
    // -------------------------------------------------------------------------
    assign mem_word = mem[word_idx];

    always_comb begin
        byte_val  = 8'(mem_word >> {lane, 3'b000});
        half_val  = lane[1] ? mem_word[31:16] : mem_word[15:0];
        load_data = '0;
        case (lat_funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_W:    load_data = mem_word;
            F3_BU:   load_data = {24'd0, byte_val};
            F3_HU:   load_data = {16'd0, half_val};
            default: load_data = '0;
        endcase
    end

    // Read-modify-write of the addressed word; untouched bytes keep their value.
    always_comb begin
        wr_word = mem_word;
        case (lat_funct3[1:0])
            2'd0: wr_word[{lane, 3'b000} +: 8] = lat_wdata[7:0];
            2'd1: begin
                if (lane[1]) begin
                    wr_word[31:16] = lat_wdata[15:0];
                end else begin
                    wr_word[15:0] = lat_wdata[15:0];
                end
            end
            2'd2:    wr_word = lat_wdata;
            default: wr_word = mem_word;
        endcase
    end

    // Storage has no reset. A reset asserted before the access edge forces the
    // FSM to IDLE, so mem_we cannot fire for an aborted store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wr_word;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            StIdle: begin
                if (req_valid) begin
                    state_next = StWait;
                end
            end
            StWait: begin
                if (cnt == 4'd0) begin
                    state_next = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_next = StIdle;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            StIdle:  req_ready = 1'b1;
            StWait:  req_ready = 1'b0;
            StResp:  rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

    // -------------------------------------------------------------------------
    // Request latch, wait counter and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            rdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        cnt        <= 4'(WAIT_CYCLES);
                    end
                end
                StWait: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Stores and faults return zero data.
                        rdata_reg <= (lat_we || access_err) ? 32'd0 : load_data;
                        err_reg   <= access_err;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b0;
                    end
                end
                default: begin
                    cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. A directed vector table covers the
// byte/halfword/word load and store cases and the fault cases. Hand-written
// sequences cover backpressure and reset in the middle of a transaction.
// Randomized transactions are then checked against a byte-array reference model.
// Honours DMEM_MISALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int unsigned DEPTH_WORDS = 256;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam logic [31:0] ADDR_BASE   = 32'h0000_0000;
    localparam int unsigned MEM_BYTES   = DEPTH_WORDS * 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    // Reference storage: a flat byte array addressed by offset from ADDR_BASE.
    logic [7:0] ref_mem [MEM_BYTES];

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_BASE   (ADDR_BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference model: size and sign come from funct3, and the data is
    // assembled byte by byte from the flat array.
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic err);
        int unsigned size;
        logic        legal;
        logic [31:0] a;
        rd  = '0;
        err = 1'b0;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        a     = addr - ADDR_BASE;
        if (!legal || addr < ADDR_BASE || a >= MEM_BYTES) begin
            err = 1'b1;
            return;
        end
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((a % size) != 0) begin
            err = 1'b1;
            return;
        end
`else
        a = a - (a % size);
`endif
        if (we) begin
            for (int i = 0; i < int'(size); i++) ref_mem[a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < int'(size); i++) rd[8*i +: 8] = ref_mem[a + i];
            if (!f3[2] && size < 4 && rd[8*size-1]) begin
                for (int i = int'(size); i < 4; i++) rd[8*i +: 8] = 8'hFF;
            end
        end
    endtask

    // Present a request and return 1 ns after the edge that accepts it.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            errors++;
            $display("FAIL issue: req_ready never rose for addr %h", addr);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count edges from the accept edge until rsp_valid is seen, then complete
    // the response handshake.
    task automatic collect(output logic [31:0] rd, output logic err, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 64);
        rd  = rsp_rdata;
        err = rsp_err;
        if (!rsp_valid) begin
            lat = 999;
            return;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
        int lat;
        issue(we, f3, addr, wd);
        collect(rd, err, lat);
        check({name, " latency"}, lat, WAIT_CYCLES + 1);
    endtask

    task automatic add_vec(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin : main
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        int          lat;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Give the storage a known value everywhere.
        for (int w = 0; w < int'(DEPTH_WORDS); w++) begin
            run_txn("init", 1'b1, 3'd2, ADDR_BASE + 32'(w * 4), 32'd0, rd, err);
        end

        // Directed vectors, in order: each builds on the stores before it.
        add_vec("sw 0x10",     1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0);
        add_vec("lw 0x10",     0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0);
        add_vec("sb 0x13",     1, 3'd0, 32'h13, 32'h00000080, 32'h0,        0);
        add_vec("lb 0x13",     0, 3'd0, 32'h13, 32'h0,        32'hFFFFFF80, 0);
        add_vec("lbu 0x13",    0, 3'd4, 32'h13, 32'h0,        32'h00000080, 0);
        add_vec("lw 0x10 b",   0, 3'd2, 32'h10, 32'h0,        32'h80ADBEEF, 0);
        add_vec("sh 0x12",     1, 3'd1, 32'h12, 32'h00007FFF, 32'h0,        0);
        add_vec("lh 0x12",     0, 3'd1, 32'h12, 32'h0,        32'h00007FFF, 0);
        add_vec("lhu 0x10",    0, 3'd5, 32'h10, 32'h0,        32'h0000BEEF, 0);
        add_vec("lh 0x10",     0, 3'd1, 32'h10, 32'h0,        32'hFFFFBEEF, 0);
        add_vec("lb 0x10",     0, 3'd0, 32'h10, 32'h0,        32'hFFFFFFEF, 0);
        add_vec("lw 0x400",    0, 3'd2, 32'h400, 32'h0,       32'h0,        1);
        add_vec("ld f3=3",     0, 3'd3, 32'h10, 32'h0,        32'h0,        1);
        add_vec("sw 0x400",    1, 3'd2, 32'h400, 32'hFFFFFFFF, 32'h0,       1);
        add_vec("sw f3=4",     1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0,        1);
        add_vec("ld top",      0, 3'd2, 32'hFFFFFFFC, 32'h0,  32'h0,        1);
        add_vec("lw 0x10 c",   0, 3'd2, 32'h10, 32'h0,        32'h7FFFBEEF, 0);
        add_vec("lw 0x3fc",    0, 3'd2, 32'h3FC, 32'h0,       32'h0,        0);
`ifdef DMEM_MISALIGN_CHECK_EN
        add_vec("lh 0x11 mis", 0, 3'd1, 32'h11, 32'h0,        32'h0,        1);
        add_vec("lw 0x13 mis", 0, 3'd2, 32'h13, 32'h0,        32'h0,        1);
        add_vec("sw 0x11 mis", 1, 3'd2, 32'h11, 32'h11111111, 32'h0,        1);
`else
        add_vec("lh 0x11 mis", 0, 3'd1, 32'h11, 32'h0,        32'hFFFFBEEF, 0);
        add_vec("lw 0x13 mis", 0, 3'd2, 32'h13, 32'h0,        32'h7FFFBEEF, 0);
        add_vec("sw 0x11 mis", 1, 3'd2, 32'h11, 32'h11111111, 32'h0,        0);
`endif
        add_vec("lw 0x10 d",   0, 3'd2, 32'h10, 32'h0,
`ifdef DMEM_MISALIGN_CHECK_EN
                32'h7FFFBEEF,
`else
                32'h11111111,
`endif
                0);

        foreach (vecs[i]) begin
            ref_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, exp_rd, exp_err);
            run_txn(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err);
            check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, " err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
        end

        // Backpressure: response held while a new request waits.
        ref_access(1'b0, 3'd2, 32'h10, 32'h0, exp_rd, exp_err);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 64);
        check("bp latency", lat, WAIT_CYCLES + 1);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h3FC;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp rsp_valid held", {31'd0, rsp_valid}, 32'd1);
            check("bp rsp_rdata held", rsp_rdata, exp_rd);
            check("bp req_ready low", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("bp idle req_ready", {31'd0, req_ready}, 32'd1);
        check("bp rsp_valid cleared", {31'd0, rsp_valid}, 32'd0);
        check("bp rsp_rdata cleared", rsp_rdata, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("bp accepted", {31'd0, req_ready}, 32'd0);
        ref_access(1'b0, 3'd2, 32'h3FC, 32'h0, exp_rd, exp_err);
        collect(rd, err, lat);
        check("bp second latency", lat, WAIT_CYCLES + 1);
        check("bp second rdata", rd, exp_rd);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("bp no extra rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Reset during WAIT aborts a store.
        ref_access(1'b1, 3'd2, 32'h20, 32'hA5A50F0F, exp_rd, exp_err);
        run_txn("sw 0x20 prior", 1'b1, 3'd2, 32'h20, 32'hA5A50F0F, rd, err);
        issue(1'b1, 3'd2, 32'h20, 32'h12345678);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst wait rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst wait req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        ref_access(1'b0, 3'd2, 32'h20, 32'h0, exp_rd, exp_err);
        run_txn("lw 0x20 after rst", 1'b0, 3'd2, 32'h20, 32'h0, rd, err);
        check("lw 0x20 after rst rdata", rd, exp_rd);
        check("lw 0x20 after rst err", {31'd0, err}, 32'd0);

        ref_access(1'b0, 3'd2, 32'h21, 32'h0, exp_rd, exp_err);
        run_txn("lw 0x21", 1'b0, 3'd2, 32'h21, 32'h0, rd, err);
        check("lw 0x21 rdata", rd, exp_rd);
        check("lw 0x21 err", {31'd0, err}, {31'd0, exp_err});

        // Reset during RESP drops the response.
        issue(1'b0, 3'd2, 32'h20, 32'h0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 64);
        check("rst resp seen", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        #2;
        check("rst resp dropped", {31'd0, rsp_valid}, 32'd0);
        check("rst resp rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wd;
            int unsigned sel;
            we  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            wd  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 8)       addr = ADDR_BASE + $urandom_range(0, MEM_BYTES - 1);
            else if (sel == 8) addr = ADDR_BASE + MEM_BYTES + $urandom_range(0, 1023);
            else               addr = $urandom;
            ref_access(we, f3, addr, wd, exp_rd, exp_err);
            run_txn("rand", we, f3, addr, wd, rd, err);
            check("rand rdata", rd, exp_rd);
            check("rand err", {31'd0, err}, {31'd0, exp_err});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
